// File: rtl/common_types_pkg.sv
// common_types_pkg: shared AHB types and byte-lane helper for the SRAM slave slice
//   word_t   : 32-bit data word
//   htrans_t : AHB transfer type
//   hsize_t  : supported transfer sizes (BYTE, HALF, WORD)
package common_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;
  typedef enum logic [2:0] {
    BYTE = 3'b000,
    HALF = 3'b001,
    WORD = 3'b010
  } hsize_t;
  // little-endian lane mask; the offset's low bits are ignored for wider sizes so lanes are always aligned
  function automatic logic [3:0] lane_mask(hsize_t size, logic [1:0] off);
    return size == BYTE ? 4'b0001 << off : size == HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_bus_if.sv
// ahb_bus_if: AHB-Lite slave-side bundle
//   slave_to_mux: inputs haddr, hburst, hsize, htrans, hwdata, hwrite, hsel, hready
//                 outputs hrdata, hreadyout, hresp
interface ahb_bus_if;
  import common_types_pkg::*;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  htrans_t     htrans;
  word_t       hwdata;
  logic        hwrite;
  logic        hsel;
  logic        hready;
  word_t       hrdata;
  logic        hreadyout;
  logic        hresp;
  modport slave_to_mux (
    input  haddr, hburst, hsize, htrans, hwdata, hwrite, hsel, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/sram_bank.sv
// sram_bank: flop-array word storage with per-byte write enables and a combinational read port
//   clk   : write clock
//   addr  : word index shared by read and write
//   be    : byte write enables, bit i writes wdata[8i+7:8i]
//   wdata : write data
//   rdata : word currently at addr
module sram_bank import common_types_pkg::*; #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     be,
  input  word_t                          wdata,
  output word_t                          rdata
);
  word_t mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with programmable wait states
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset (storage is not cleared)
//   ahbif : ahb_bus_if.slave_to_mux slave port
// Parameters: DEPTH_WORDS (power of two), WAIT_STATES (0..15)
// Macro AHB_SRAM_SLAVE_ERROR_EN: out-of-range, hsize>=3 and misaligned transfers answer ERROR;
// when undefined, addresses wrap, low address bits are aligned away and hsize>=3 acts as a word.
module ahb_sram_slave import common_types_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic             CLK,
  input logic             nRST,
  ahb_bus_if.slave_to_mux ahbif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          dp_valid, dp_write;
  logic [AW-1:0] dp_idx;
  logic [1:0]    dp_off;
  hsize_t        dp_size, size_in;
  logic          accept, done, take, bad, unused_ok;
  logic [3:0]    be;
  word_t         rdata;
  assign accept  = ahbif.hsel && ahbif.hready &&
                   (ahbif.htrans == HTRANS_NONSEQ || ahbif.htrans == HTRANS_SEQ);
  // done marks the last cycle of any data phase (or no data phase at all)
  assign done    = state == IDLE || state == ERR2 || (state == WAIT && cnt == 4'd0);
  // a transfer on the bus while we are still stalling cannot be legal, so it is ignored
  assign take    = accept && done;
  assign size_in = ahbif.hsize == 3'd0 ? BYTE : ahbif.hsize == 3'd1 ? HALF : WORD;
`ifdef AHB_SRAM_SLAVE_ERROR_EN
  assign bad = ahbif.haddr >= 32'(4 * DEPTH_WORDS) || ahbif.hsize > 3'd2 ||
               (ahbif.hsize == 3'd1 && ahbif.haddr[0]) ||
               (ahbif.hsize == 3'd2 && ahbif.haddr[1:0] != 2'b00);
  assign ahbif.hresp = state == ERR1 || state == ERR2;
`else
  assign bad = 1'b0;
  assign ahbif.hresp = 1'b0;
`endif
  assign unused_ok = ^{ahbif.hburst, ahbif.haddr[31:AW+2]};
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (take && bad) state_nx = ERR1;
    else if (take && WAIT_STATES > 0) begin
      state_nx = WAIT;
      cnt_nx   = 4'(WAIT_STATES);
    end
    else if (done) state_nx = IDLE;
    else if (state == ERR1) state_nx = ERR2;
    else cnt_nx = cnt - 4'd1;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_off   <= 2'b00;
      dp_size  <= BYTE;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (done) dp_valid <= take && !bad;
      if (take) begin
        dp_write <= ahbif.hwrite;
        dp_idx   <= ahbif.haddr[AW+1:2];
        dp_off   <= ahbif.haddr[1:0];
        dp_size  <= size_in;
      end
    end
  // hwdata is taken at the edge that ends the write data phase
  assign be = dp_valid && dp_write && done ? lane_mask(dp_size, dp_off) : 4'b0000;
  sram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (CLK),
    .addr  (dp_idx),
    .be    (be),
    .wdata (ahbif.hwdata),
    .rdata (rdata)
  );
  assign ahbif.hreadyout = done;
  assign ahbif.hrdata    = dp_valid && !dp_write && done ? rdata : '0;
endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-002 Parameter WAIT_STATES, default 0, data-phase cycles with hreadyout low before completion (0..15).
REQ-003 Port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 Port nRST  input  1  reset, asynchronous, active-low.
REQ-005 Port ahbif  ahb_bus_if.slave_to_mux  --  inputs haddr, hburst, hsize, htrans, hwdata, hwrite, hsel, hready; outputs hrdata, hreadyout, hresp.

Function
REQ-006 Address phase accepted when hsel=1, hready=1 and htrans is NONSEQ or SEQ; haddr, hsize, hwrite are registered at that edge.
REQ-007 IDLE or BUSY with hsel=1 and hready=1: no access; next cycle hreadyout=1, hresp=0 (zero-wait OKAY).
REQ-008 hsel=0 or hready=0: no new transfer is accepted; an in-progress data phase continues.
REQ-009 FSM states IDLE, WAIT, ERR1, ERR2; an accepted valid transfer goes to WAIT if WAIT_STATES>0, else completes in IDLE during the following cycle.
REQ-010 WAIT: a counter loaded with WAIT_STATES decrements each cycle with hreadyout=0; at zero, hreadyout=1 and the transfer completes; the state returns to IDLE or, if a new transfer is accepted that edge, reloads.
REQ-011 Write commits at the edge ending the data phase (hreadyout=1); hwdata is sampled at that edge.
REQ-012 Write byte lanes are little-endian: hsize=00 writes byte haddr[1:0]; 01 writes halfword haddr[1]; 10 writes the full word; other bytes are unchanged.
REQ-013 Read: during the completing data-phase cycle, hrdata = full word at the registered word address, irrespective of hsize; otherwise hrdata=0.
REQ-014 Back-to-back write then read of the same address returns the newly written data (the write commits before the read data phase).
REQ-015 Word index = registered haddr[log2(DEPTH_WORDS)+1:2].
REQ-016 hburst is ignored; each beat is treated independently.

Reset
REQ-017 On nRST low: state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter 0, registered phase cleared.
REQ-018 Reset mid-data-phase aborts the transfer: no memory write; storage contents are not reset.

Configuration
REQ-019 Macro AHB_SRAM_SLAVE_ERROR_EN defined: accepted transfer with haddr >= 4*DEPTH_WORDS, hsize=11, or misalignment (hsize=01 with haddr[0]=1; hsize=10 with haddr[1:0]!=0) produces ERROR.
REQ-020 ERROR is two cycles and skips wait states: ERR1 hresp=1, hreadyout=0; ERR2 hresp=1, hreadyout=1; no write occurs; hrdata=0.
REQ-021 Macro undefined: hresp is tied 0; the address wraps modulo 4*DEPTH_WORDS; misaligned low address bits are forced to alignment; hsize=11 is treated as 10.

Structure
REQ-022 common_types_pkg holds htrans_t, word_t, and a new enum hsize_t (BYTE, HALF, WORD); the FSM state enum stays local.
REQ-023 Storage is sub-module sram_bank (flop array, 4 byte-write enables, combinational read port); the FSM and decode sit in ahb_sram_slave.

Verification
REQ-024 WAIT_STATES=0, write word 0xDEADBEEF to 0x10, then read 0x10 -> data phase hreadyout=1 each cycle; hrdata=0xDEADBEEF.
REQ-025 Byte write 0xAA to 0x13 over 0x11223344 -> read 0x10 returns 0xAA223344; halfword 0x5566 to 0x12 -> 0x55663344.
REQ-026 WAIT_STATES=3, single read -> hreadyout low exactly 3 cycles, then 1 with valid hrdata; back-to-back NONSEQ pair -> 3 waits each.
REQ-027 ERROR_EN, read of 0x1000 with DEPTH_WORDS=1024 -> ERR1 (hresp=1, hreadyout=0) then ERR2 (1,1); a halfword write to 0x21 -> same response, memory unchanged.
REQ-028 Without ERROR_EN, write 0x1 to 0x1004 -> read 0x0004 returns 0x1, hresp always 0.
REQ-029 nRST asserted during the WAIT data phase of a write -> outputs at reset values immediately; the target word keeps its old value.
